// File: rtl/amiga_chipram_slot_arbiter.sv
// Chip-RAM slot sequencer and DMA/CPU arbiter: one owner per fixed-length slot, registered DRAM strobes and CPU handshake.
// Optional CPU fairness (forced CPU slot after FAIR_LIMIT stolen slots) is enabled by defining AMIGA_CPU_FAIRSLOT_EN.
module amiga_chipram_slot_arbiter #(
    parameter int SLOT_CLKS  = 8,
    parameter int FAIR_LIMIT = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DMA_REQ,
    input  logic       DMA_WR,
    output logic       DMA_GNT,
    input  logic       _AS,
    input  logic       CPU_RW,
    input  logic       _UDS,
    input  logic       _LDS,
    input  logic       CHIPSEL,
    output logic       _RAS,
    output logic       _CASU,
    output logic       _CASL,
    output logic       _RRW,
    output logic       _CDR,
    output logic       _CDW,
    output logic       _DTACK,
    output logic       CPU_WAIT,
    output logic [3:0] SLOT_PHASE
);

    localparam logic [3:0] LAST_PH = 4'(SLOT_CLKS - 1);
    localparam logic [3:0] PRE_PH  = 4'(SLOT_CLKS - 2);

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_DMA,
        OWN_CPU
    } owner_e;

    logic [3:0] phase_q, phase_d;
    owner_e     owner_q, owner_d;
    logic       casu_en_q, casu_en_d;
    logic       casl_en_q, casl_en_d;
    logic       write_q, write_d;
    logic       abort_q, abort_d;
    logic       served_q, served_d;
    logic       ras_n_q, ras_n_d;
    logic       casu_n_q, casu_n_d;
    logic       casl_n_q, casl_n_d;
    logic       rrw_n_q, rrw_n_d;
    logic       cdr_n_q, cdr_n_d;
    logic       cdw_n_q, cdw_n_d;
    logic       dtack_n_q, dtack_n_d;
    logic       dma_gnt_q, dma_gnt_d;
    logic       cpu_wait_q, cpu_wait_d;

    logic       cpu_req;
    logic       slot_start;
    logic       force_cpu;
    logic       in_slot;
    logic       ras_window;
    logic       cas_window;
    logic       cpu_live;

    assign cpu_req    = !_AS && CHIPSEL && (!_UDS || !_LDS) && !served_q;
    assign slot_start = (phase_q == LAST_PH);

`ifdef AMIGA_CPU_FAIRSLOT_EN
    localparam logic [3:0] FAIR_LIMIT_C = 4'(FAIR_LIMIT);

    logic [3:0] fair_q, fair_d;

    assign force_cpu = cpu_req && (fair_q == FAIR_LIMIT_C);

    // Counts DMA slots taken while the CPU was kept waiting; never exceeds the limit.
    always_comb begin
        fair_d = fair_q;
        if (slot_start) begin
            fair_d = (owner_d == OWN_DMA && cpu_req) ? fair_q + 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fair_q <= 4'd0;
        end else begin
            fair_q <= fair_d;
        end
    end
`else
    logic unused_fair_limit;

    assign force_cpu         = 1'b0;
    assign unused_fair_limit = ^4'(FAIR_LIMIT);
`endif

    // Owner, lanes and direction are decided on the edge into phase 0 and frozen for the slot.
    always_comb begin
        phase_d   = slot_start ? 4'd0 : phase_q + 4'd1;
        owner_d   = owner_q;
        casu_en_d = casu_en_q;
        casl_en_d = casl_en_q;
        write_d   = write_q;
        if (slot_start) begin
            if (DMA_REQ && !force_cpu) begin
                owner_d   = OWN_DMA;
                casu_en_d = 1'b1;
                casl_en_d = 1'b1;
                write_d   = DMA_WR;
            end else if (cpu_req) begin
                owner_d   = OWN_CPU;
                casu_en_d = !_UDS;
                casl_en_d = !_LDS;
                write_d   = !CPU_RW;
            end else begin
                owner_d   = OWN_IDLE;
                casu_en_d = 1'b0;
                casl_en_d = 1'b0;
                write_d   = 1'b0;
            end
        end
    end

    always_comb begin
        abort_d    = slot_start ? 1'b0 : (abort_q || (owner_q == OWN_CPU && _AS));
        in_slot    = (owner_d != OWN_IDLE);
        ras_window = (phase_d >= 4'd1) && (phase_d <= PRE_PH);
        cas_window = (phase_d >= 4'd3) && (phase_d <= PRE_PH);
        cpu_live   = (owner_d == OWN_CPU) && !abort_d;

        ras_n_d    = !(in_slot && ras_window);
        casu_n_d   = !(in_slot && cas_window && casu_en_d);
        casl_n_d   = !(in_slot && cas_window && casl_en_d);
        rrw_n_d    = !(in_slot && ras_window && write_d);
        cdr_n_d    = !(cpu_live && !write_d && (phase_d >= 4'd3));
        cdw_n_d    = !(cpu_live && write_d && ras_window);

        // _DTACK latches low until the CPU drops _AS; an aborted slot never acknowledges.
        if (_AS) begin
            dtack_n_d = 1'b1;
        end else if (!dtack_n_q) begin
            dtack_n_d = 1'b0;
        end else begin
            dtack_n_d = !(cpu_live && (phase_d == PRE_PH));
        end

        if (_AS) begin
            served_d = 1'b0;
        end else if (!dtack_n_d) begin
            served_d = 1'b1;
        end else begin
            served_d = served_q;
        end

        dma_gnt_d  = slot_start && (owner_d == OWN_DMA);
        cpu_wait_d = cpu_req && (owner_d != OWN_CPU);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q    <= 4'd0;
            owner_q    <= OWN_IDLE;
            casu_en_q  <= 1'b0;
            casl_en_q  <= 1'b0;
            write_q    <= 1'b0;
            abort_q    <= 1'b0;
            served_q   <= 1'b0;
            ras_n_q    <= 1'b1;
            casu_n_q   <= 1'b1;
            casl_n_q   <= 1'b1;
            rrw_n_q    <= 1'b1;
            cdr_n_q    <= 1'b1;
            cdw_n_q    <= 1'b1;
            dtack_n_q  <= 1'b1;
            dma_gnt_q  <= 1'b0;
            cpu_wait_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            owner_q    <= owner_d;
            casu_en_q  <= casu_en_d;
            casl_en_q  <= casl_en_d;
            write_q    <= write_d;
            abort_q    <= abort_d;
            served_q   <= served_d;
            ras_n_q    <= ras_n_d;
            casu_n_q   <= casu_n_d;
            casl_n_q   <= casl_n_d;
            rrw_n_q    <= rrw_n_d;
            cdr_n_q    <= cdr_n_d;
            cdw_n_q    <= cdw_n_d;
            dtack_n_q  <= dtack_n_d;
            dma_gnt_q  <= dma_gnt_d;
            cpu_wait_q <= cpu_wait_d;
        end
    end

    assign DMA_GNT    = dma_gnt_q;
    assign _RAS       = ras_n_q;
    assign _CASU      = casu_n_q;
    assign _CASL      = casl_n_q;
    assign _RRW       = rrw_n_q;
    assign _CDR       = cdr_n_q;
    assign _CDW       = cdw_n_q;
    assign _DTACK     = dtack_n_q;
    assign CPU_WAIT   = cpu_wait_q;
    assign SLOT_PHASE = phase_q;

endmodule
